// File: rtl/mux16_rr_if.sv
//==============================================================================
// Module   : mux16_rr_if
// Brief    : Request/grant bundle between 16 requesters and the mux16 scheduler.
//            Timeout signal present only when MUX16_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mux16_rr_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        gnt_valid;
`ifdef MUX16_TIMEOUT_EN
  logic        timeout;

  modport master (output req, done, input sel, gnt, gnt_valid, timeout);
  modport slave  (input req, done, output sel, gnt, gnt_valid, timeout);
`else
  modport master (output req, done, input sel, gnt, gnt_valid);
  modport slave  (input req, done, output sel, gnt, gnt_valid);
`endif
endinterface

`default_nettype wire

// File: rtl/mux16_rr_scheduler.sv
//==============================================================================
// Module   : mux16_rr_scheduler
// Brief    : Round-robin grant/select generator for a shared 16:1 mux.
//            Optional forced release on long holds: define MUX16_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux16_rr_scheduler #(
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mux16_rr_if.slave    bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  if (HOLD_MAX > (2**CNT_W) - 1) begin : g_param_chk
    $error("HOLD_MAX does not fit in CNT_W bits");
  end

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [3:0] r_ptr;
  logic [3:0] r_sel;
  logic [3:0] w_winner;
  logic [3:0] w_idx;
  logic       w_found;
  logic       w_release;
  logic       w_revoke;
  logic       w_end;

  // First requester at or after ptr, wrapping 15 -> 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int i = 0; i < 16; i++) begin
      w_idx = r_ptr + 4'(i);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_release = bus.done | ~bus.req[r_sel];

`ifdef MUX16_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // A normal release wins over a revoke in the same cycle.
  assign w_revoke = ((r_cnt + 1'b1) == CNT_W'(HOLD_MAX)) & ~w_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == S_BUSY) && w_revoke;
      if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end
`else
  assign w_revoke = 1'b0;
`endif

  assign w_end = w_release | w_revoke;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 4'd0;
      r_sel   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_sel <= w_winner;
      end
      if (r_state == S_BUSY && w_end) begin
        r_ptr <= r_sel + 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_end)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.sel       = r_sel;
    bus.gnt_valid = (r_state == S_BUSY);
    bus.gnt       = '0;
    if (r_state == S_BUSY) begin
      bus.gnt[r_sel] = 1'b1;
    end
`ifdef MUX16_TIMEOUT_EN
    bus.timeout   = r_timeout;
`endif
  end

endmodule

`default_nettype wire
